gcd_engine: RTL and testbench

//  Multi-cycle GCD engine using repeated subtraction (Euclid) over WIDTH-bit unsigned operands.

---
 rtl/gcd_engine_if.sv | 33 +++
 rtl/gcd_engine.sv | 101 ++++++++++
 tb/tb_gcd_engine.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/gcd_engine_if.sv
// Operand/result handshake bundle for gcd_engine; master drives operands and result-accept.
// The iteration-count output exists only when GCD_ITER_COUNT_EN is defined.
interface gcd_engine_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] gcd_out;
  logic             busy;
`ifdef GCD_ITER_COUNT_EN
  logic [WIDTH-1:0] iter_count;
`endif

  modport master (
    output in_valid, a_in, b_in, out_ready,
`ifdef GCD_ITER_COUNT_EN
    input  iter_count,
`endif
    input  in_ready, out_valid, gcd_out, busy
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
`ifdef GCD_ITER_COUNT_EN
    output iter_count,
`endif
    output in_ready, out_valid, gcd_out, busy
  );
endinterface

// File: rtl/gcd_engine.sv
// Multi-cycle GCD engine by repeated subtraction; one subtract/compare step per clock.
// Optional GCD_ITER_COUNT_EN adds a saturating count of subtract steps.
//   state  | meaning
//   IDLE   | ready for an operand pair
//   CALC   | subtracting smaller from larger until equal
//   DONE   | result presented, waiting for sink
module gcd_engine #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  gcd_engine_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic             accept;
  logic             ops_zero;
  logic             ab_equal;

  assign accept   = (state_q == S_IDLE) && bus.in_valid;
  assign ops_zero = (bus.a_in == '0) || (bus.b_in == '0);
  assign ab_equal = (a_q == b_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      gcd_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gcd_q   <= gcd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = ops_zero ? S_DONE : S_CALC;
      S_CALC:  if (ab_equal) state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Larger minus smaller only, so the subtraction can never wrap.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    gcd_d = gcd_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d = bus.a_in;
          b_d = bus.b_in;
          if (ops_zero) gcd_d = bus.a_in | bus.b_in;
        end
      end
      S_CALC: begin
        if (ab_equal)       gcd_d = a_q;
        else if (a_q > b_q) a_d   = a_q - b_q;
        else                b_d   = b_q - a_q;
      end
      default: ;
    endcase
  end

`ifdef GCD_ITER_COUNT_EN
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept)
      cnt_d = '0;
    else if ((state_q == S_CALC) && !ab_equal && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  assign bus.iter_count = cnt_q;
`endif

  always_comb begin
    bus.in_ready  = (state_q == S_IDLE) && !rst;
    bus.out_valid = (state_q == S_DONE);
    bus.busy      = (state_q != S_IDLE);
    bus.gcd_out   = gcd_q;
  end

endmodule

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine: directed corner cases plus random operands
// checked against an Euclid-by-division reference model.
module tb_gcd_engine;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   n_asserts;
  int   n_fail;

  gcd_engine_if #(.WIDTH(WIDTH)) bus ();

  gcd_engine #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // gcd via division; subtract count is the sum of Euclid quotients minus the final equal step
  function automatic void ref_gcd(input int a, input int b, output int g, output int n_sub,
                                  output int edges);
    int x, y, t, s;
    if (a == 0 || b == 0) begin
      g = a | b; n_sub = 0; edges = 0;
    end else begin
      x = a; y = b; s = 0;
      while (y != 0) begin
        s += x / y;
        t = x % y;
        x = y;
        y = t;
      end
      g = x; n_sub = s - 1; edges = s;
    end
  endfunction

  task automatic wait_result(input string tag, output int edges);
    edges = 0;
    @(negedge clk);
    while (!bus.out_valid && edges < 400) begin
      @(negedge clk);
      edges++;
    end
    if (!bus.out_valid) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic run_op(input int a, input int b, input int hold, input string tag);
    int g, n_sub, exp_edges, edges, tmo;
    ref_gcd(a, b, g, n_sub, exp_edges);
    @(negedge clk);
    bus.a_in      = a[WIDTH-1:0];
    bus.b_in      = b[WIDTH-1:0];
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tmo = 0;
    while (!bus.in_ready && tmo < 20) begin
      @(negedge clk);
      tmo++;
    end
    check({tag, "_in_ready"}, bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_result(tag, edges);
    check({tag, "_latency"}, edges, exp_edges);
    check({tag, "_gcd"}, bus.gcd_out, g);
    check({tag, "_busy"}, bus.busy, 1);
    check({tag, "_no_in_ready"}, bus.in_ready, 0);
`ifdef GCD_ITER_COUNT_EN
    check({tag, "_iter"}, bus.iter_count, (n_sub > 255) ? 255 : n_sub);
`endif
    for (int k = 0; k < hold; k++) begin
      bus.in_valid = k[0];
      bus.a_in     = WIDTH'($urandom_range(1, 255));
      bus.b_in     = WIDTH'($urandom_range(1, 255));
      @(negedge clk);
      check({tag, "_hold_valid"}, bus.out_valid, 1);
      check({tag, "_hold_gcd"}, bus.gcd_out, g);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_drop_valid"}, bus.out_valid, 0);
    check({tag, "_idle_ready"}, bus.in_ready, 1);
    check({tag, "_idle_busy"}, bus.busy, 0);
  endtask

  initial begin
    int g, n_sub, exp_edges, edges, ra, rb, tmo;
    n_asserts     = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.out_ready = 1'b0;

    #2;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_gcd", bus.gcd_out, 0);
`ifdef GCD_ITER_COUNT_EN
    check("rst_iter", bus.iter_count, 0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(12, 8, 0, "g12_8");
    run_op(0, 7, 0, "g0_7");
    run_op(0, 0, 0, "g0_0");
    run_op(9, 9, 0, "g9_9");
    run_op(255, 1, 0, "g255_1");
    run_op(48, 18, 10, "g48_18_hold");

    // Asynchronous reset in the middle of a computation
    @(negedge clk);
    bus.a_in = 8'd200; bus.b_in = 8'd3; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_in_ready", bus.in_ready, 0);
    check("arst_gcd", bus.gcd_out, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("arst_no_result", bus.out_valid, 0);
    run_op(10, 4, 0, "g10_4_post_rst");

    for (int i = 0; i < 8; i++) begin
      ra = (i == 0) ? 0 : int'($urandom_range(1, 255));
      rb = int'($urandom_range(1, 255));
      run_op(ra, rb, i % 3, "rand");
    end

    // Back-to-back stream: in_valid held high, sink always ready
    @(negedge clk);
    ra = int'($urandom_range(0, 255));
    rb = int'($urandom_range(1, 255));
    bus.a_in = ra[WIDTH-1:0]; bus.b_in = rb[WIDTH-1:0];
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tmo = 0;
      while (!bus.in_ready && tmo < 20) begin
        @(negedge clk);
        tmo++;
      end
      check("b2b_ready_high", bus.in_ready, 1);
      ref_gcd(ra, rb, g, n_sub, exp_edges);
      @(posedge clk);
      #1;
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(1, 255));
      bus.a_in = ra[WIDTH-1:0]; bus.b_in = rb[WIDTH-1:0];
      wait_result("b2b", edges);
      check("b2b_ready_low", bus.in_ready, 0);
      check("b2b_latency", edges, exp_edges);
      check("b2b_gcd", bus.gcd_out, g);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("final_idle", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
